// File: rtl/pipelined_csel_adder.sv
// rtl/pipelined_csel_adder.sv - carry-select adder/subtractor split over STAGES register stages
module pipelined_csel_adder #(
    parameter int N      = 32,
    parameter int BLK    = 4,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    input  logic         sub,
    input  logic         sat,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] Sum,
    output logic         Cout,
    output logic         Overflow
);
    localparam int BPS = (N / BLK) / STAGES;
    localparam int SW  = BPS * BLK;

    logic en;

    assign en       = out_ready | ~out_valid;
    assign in_ready = rst | en;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = s * SW;
        localparam int HI = LO + SW;

        logic            vld_i, cy_i, sub_i, sat_i;
        logic [N-1:LO]   a_i, b_i;
        logic [HI-1:LO]  bb;
        logic [HI-1:LO]  sum_hi;
        logic [HI-1:0]   sum_o;
        logic            c;
        logic [BLK:0]    r0, r1, r;

        // Stage inputs come from the ports for stage 0, else from the previous boundary register
        if (s == 0) begin : g_in
            assign vld_i = in_valid;
            assign a_i   = A;
            assign b_i   = B;
            assign sub_i = sub;
            assign sat_i = sat;
            assign cy_i  = sub ? 1'b1 : Cin;
            assign sum_o = sum_hi;
        end else begin : g_in
            assign vld_i = g_stage[s-1].g_reg.vld_q;
            assign a_i   = g_stage[s-1].g_reg.a_q;
            assign b_i   = g_stage[s-1].g_reg.b_q;
            assign sub_i = g_stage[s-1].g_reg.sub_q;
            assign sat_i = g_stage[s-1].g_reg.sat_q;
            assign cy_i  = g_stage[s-1].g_reg.cy_q;
            assign sum_o = {sum_hi, g_stage[s-1].g_reg.sum_q};
        end

        assign bb = sub_i ? ~b_i[HI-1:LO] : b_i[HI-1:LO];

        always_comb begin
            c      = cy_i;
            sum_hi = '0;
            r0     = '0;
            r1     = '0;
            r      = '0;
            for (int k = 0; k < BPS; k++) begin
                r0 = {1'b0, a_i[LO + k*BLK +: BLK]} + {1'b0, bb[LO + k*BLK +: BLK]};
                r1 = r0 + (BLK+1)'(1);
                // Only the very first block ripples its carry in; all others select
                if (s == 0 && k == 0)
                    r = r0 + (BLK+1)'(c);
                else
                    r = c ? r1 : r0;
                sum_hi[LO + k*BLK +: BLK] = r[BLK-1:0];
                c = r[BLK];
            end
        end

        if (s < STAGES-1) begin : g_reg
            logic          vld_q, cy_q, sub_q, sat_q;
            logic [N-1:HI] a_q, b_q;
            logic [HI-1:0] sum_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= 1'b0;
                    cy_q  <= 1'b0;
                    sub_q <= 1'b0;
                    sat_q <= 1'b0;
                    a_q   <= '0;
                    b_q   <= '0;
                    sum_q <= '0;
                end else if (en) begin
                    vld_q <= vld_i;
                    cy_q  <= c;
                    sub_q <= sub_i;
                    sat_q <= sat_i;
                    a_q   <= a_i[N-1:HI];
                    b_q   <= b_i[N-1:HI];
                    sum_q <= sum_o;
                end
            end
        end else begin : g_out
            logic         ov;
            logic [N-1:0] sat_val;

            assign ov      = (a_i[N-1] == bb[N-1]) && (sum_o[N-1] != a_i[N-1]);
            assign sat_val = a_i[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};

            always_ff @(posedge clk) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    Sum       <= '0;
                    Cout      <= 1'b0;
                    Overflow  <= 1'b0;
                end else if (en) begin
                    out_valid <= vld_i;
                    Sum       <= (sat_i && ov) ? sat_val : sum_o;
                    Cout      <= c;
                    Overflow  <= ov;
                end
            end
        end
    end
endmodule

// File: tb/tb_pipelined_csel_adder.sv
// tb/tb_pipelined_csel_adder.sv - directed and random checks of pipelined_csel_adder against an arithmetic model
module tb_pipelined_csel_adder;
    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, Cin, sub, sat;
    logic        out_valid, out_ready, Cout, Overflow;
    logic [31:0] A, B, Sum;

    int n_assert = 0;
    int n_fail   = 0;
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    pipelined_csel_adder #(.N(32), .BLK(4), .STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .Cin(Cin), .sub(sub), .sat(sat),
        .out_valid(out_valid), .out_ready(out_ready),
        .Sum(Sum), .Cout(Cout), .Overflow(Overflow)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Result as {Sum, Cout, Overflow}, from signed/unsigned integer arithmetic
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic cin, input logic sb, input logic st);
        longint sa, sbv, r, ua;
        logic [31:0] raw, res;
        logic cout, ov;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        if (sb) begin
            r    = sa - sbv;
            raw  = a - b;
            cout = (a >= b);
        end else begin
            r    = sa + sbv + (cin ? 1 : 0);
            ua   = longint'({32'b0, a}) + longint'({32'b0, b}) + (cin ? 1 : 0);
            raw  = ua[31:0];
            cout = ua[32];
        end
        ov  = (r > 64'sh7FFFFFFF) || (r < -64'sh80000000);
        res = (st && ov) ? ((r > 0) ? 32'h7FFFFFFF : 32'h80000000) : raw;
        return {res, cout, ov};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h7FFFFFFF;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h00000000;
            default: return $urandom;
        endcase
    endfunction

    task automatic single(input logic [31:0] a, input logic [31:0] b, input logic cin,
                          input logic sb, input logic st,
                          input logic [31:0] esum, input logic ecout, input logic eov);
        A = a; B = b; Cin = cin; sub = sb; sat = st;
        in_valid = 1'b1; out_ready = 1'b1;
        #1;
        chk("accept_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("latency_early", out_valid, 0);
        @(posedge clk); #1;
        chk("latency_valid", out_valid, 1);
        chk("dir_sum", Sum, esum);
        chk("dir_cout", Cout, ecout);
        chk("dir_ovf", Overflow, eov);
    endtask

    task automatic cycle(input logic iv, input logic ordy);
        logic acc, drn, held;
        logic [33:0] hv, e;
        in_valid = iv; out_ready = ordy;
        if (iv) begin
            A = pick(); B = pick();
            Cin = 1'($urandom_range(0, 1));
            sub = 1'($urandom_range(0, 1));
            sat = 1'($urandom_range(0, 1));
        end
        #1;
        acc  = in_valid && in_ready;
        drn  = out_valid && out_ready;
        held = out_valid && !out_ready;
        hv   = {Sum, Cout, Overflow};
        if (held) chk("stall_in_ready", in_ready, 0);
        if (drn) begin
            chk("out_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("result", {Sum, Cout, Overflow}, e);
            end
        end
        if (acc) exp_q.push_back(model(A, B, Cin, sub, sat));
        @(posedge clk); #1;
        if (held) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_hold", {Sum, Cout, Overflow}, hv);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        A = 32'h12345678; B = 32'h1; Cin = 1'b0; sub = 1'b0; sat = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", Sum, 0);
        chk("rst_cout", Cout, 0);
        chk("rst_ovf", Overflow, 0);
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("no_capture_in_reset", out_valid, 0);
        end

        single(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0);
        single(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1);
        single(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1);
        single(32'h00000005, 32'h00000007, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0);
        single(32'h80000000, 32'h00000001, 1'b0, 1'b1, 1'b1, 32'h80000000, 1'b1, 1'b1);
        single(32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 32'h80000000, 1'b1, 1'b1);
        single(32'h00000001, 32'h00000002, 1'b1, 1'b0, 1'b1, 32'h00000004, 1'b0, 1'b0);
        single(32'h0000000F, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h00000010, 1'b0, 1'b0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("drain_idle", out_valid, 0);

        // Backpressure: fill under stall, then release and drain in order
        repeat (4) cycle(1'b1, 1'b0);
        repeat (4) cycle(1'b1, 1'b1);
        repeat (6) cycle(1'b0, 1'b1);
        chk("bp_drained", exp_q.size(), 0);

        // Reset with transactions in flight
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        rst = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", Sum, 0);
        chk("midrst_in_ready", in_ready, 1);
        exp_q.delete();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("no_stale", out_valid, 0);
        end

        repeat (3000) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        repeat (8) cycle(1'b0, 1'b1);
        chk("final_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
